// File: rtl/dma_mc_engine.sv
// dma_mc_engine: multi-channel DMA with one shared bus-master port.
// Channels are granted round-robin per burst; each word is read into a
// holding register and then written, with bus_ready wait states.
// Optional build macro DMA_MC_IRQ_EN adds a sticky completion status
// register with per-channel clear and mask, and a registered irq output.
//
// state | meaning
// IDLE  | no channel busy, bus quiet
// ARB   | pick next busy channel from rr pointer, load burst budget
// RD    | read src of granted channel, wait for bus_ready
// WR    | write hold register to dst, wait for bus_ready
// UPD   | advance addresses and counters, decide next grant
module dma_mc_engine #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 4,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_cnt,
`ifdef DMA_MC_IRQ_EN
  output logic              irq,
  input  logic [NUM_CH-1:0] irq_clr,
  input  logic [NUM_CH-1:0] irq_mask,
`endif
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_done,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, ARB, RD, WR, UPD} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] done_cfg_q;
  logic [CHW-1:0]    g_q;
  logic [CHW-1:0]    rr_q;
  logic [BW-1:0]     burst_q;
  logic [DATA_W-1:0] hold_q;

  logic [NUM_CH-1:0] cfg_sel;
  logic [NUM_CH-1:0] upd_sel;
  logic [CHW-1:0]    arb_ch;
  logic              arb_found;
  logic              others_busy;
  logic              cfg_start;
  logic              last_word;
  logic              burst_end;

  assign ch_busy   = busy_q;
  assign last_word = (cnt_q[g_q] == CNT_W'(1));
  assign burst_end = (burst_q == BW'(1));
  assign cfg_start = (|(cfg_sel & ~busy_q)) && (cfg_cnt != '0);

  // Channel decodes and round-robin search starting at rr_q
  always_comb begin
    int idx;
    cfg_sel     = '0;
    upd_sel     = '0;
    arb_found   = 1'b0;
    arb_ch      = '0;
    others_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_sel[i] = cfg_wr && (cfg_ch == CHW'(i));
      upd_sel[i] = (state_q == UPD) && (g_q == CHW'(i));
      if (busy_q[i] && (g_q != CHW'(i))) others_busy = 1'b1;
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!arb_found && busy_q[CHW'(idx)]) begin
        arb_found = 1'b1;
        arb_ch    = CHW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((|busy_q) || cfg_start) state_d = ARB;
      ARB:  state_d = arb_found ? RD : IDLE;
      RD:   if (bus_ready) state_d = WR;
      WR:   if (bus_ready) state_d = UPD;
      UPD: begin
        if (last_word)      state_d = others_busy ? ARB : IDLE;
        else if (burst_end) state_d = ARB;
        else                state_d = RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and completion pulses, decoded from the current state
  always_comb begin
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    ch_done   = done_cfg_q;
    case (state_q)
      RD: begin
        bus_rd   = 1'b1;
        bus_addr = src_q[g_q];
      end
      WR: begin
        bus_wr    = 1'b1;
        bus_addr  = dst_q[g_q];
        bus_wdata = hold_q;
      end
      UPD: if (last_word) ch_done = done_cfg_q | upd_sel;
      default: ;
    endcase
  end

  // Channel registers, grant, burst budget, hold register and rr pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      busy_q     <= '0;
      done_cfg_q <= '0;
      g_q        <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      hold_q     <= '0;
    end else begin
      done_cfg_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_sel[i] && !busy_q[i]) begin
          src_q[i]      <= cfg_src;
          dst_q[i]      <= cfg_dst;
          cnt_q[i]      <= cfg_cnt;
          busy_q[i]     <= (cfg_cnt != '0);
          done_cfg_q[i] <= (cfg_cnt == '0);
        end else if (upd_sel[i]) begin
          src_q[i] <= src_q[i] + ADDR_W'(1);
          dst_q[i] <= dst_q[i] + ADDR_W'(1);
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          if (last_word) busy_q[i] <= 1'b0;
        end
      end
      if (state_q == ARB) begin
        g_q     <= arb_ch;
        burst_q <= BW'(BURST_LEN);
      end
      if ((state_q == RD) && bus_ready) hold_q <= bus_rdata;
      if (state_q == UPD) begin
        burst_q <= burst_q - BW'(1);
        if (last_word || burst_end)
          rr_q <= (g_q == CHW'(NUM_CH - 1)) ? '0 : g_q + CHW'(1);
      end
    end
  end

`ifdef DMA_MC_IRQ_EN
  logic [NUM_CH-1:0] status_q;

  // Sticky completion status; a new completion beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= (status_q & ~irq_clr) | ch_done;
      irq      <= |(status_q & ~irq_mask);
    end
  end
`endif

endmodule

// File: doc/dma_mc_engine.md
Name: dma_mc_engine

Overview:
Parametrised multi-channel successor to the single-channel DMA in the processor/ram/io subsystem. NUM_CH independent channels, each programmed with source, destination and word count by the processor over a config port. Channels share one bus-master port to ram/io. Round-robin arbitration at burst granularity. Each word is read into a holding register, then written, with bus_ready wait-state handshaking.

Parameters:
NUM_CH, 4, number of channels (1..8)
DATA_W, 32, bus data width
ADDR_W, 32, bus address width
CNT_W, 8, word-count width per channel
BURST_LEN, 4, max words moved per grant before re-arbitration (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_wr  input  1  config write strobe, one cycle
cfg_ch  input  $clog2(NUM_CH)  channel selected by cfg_wr
cfg_src  input  ADDR_W  source start address
cfg_dst  input  ADDR_W  destination start address
cfg_cnt  input  CNT_W  words to move
ch_busy  output  NUM_CH  per-channel active flag
ch_done  output  NUM_CH  one-cycle pulse per channel on completion
bus_rd  output  1  bus read request
bus_wr  output  1  bus write request
bus_addr  output  ADDR_W  bus address
bus_wdata  output  DATA_W  write data
bus_rdata  input  DATA_W  read data, valid when bus_ready is high during bus_rd
bus_ready  input  1  slave completes the current access this cycle

Behaviour:
- Reset (async, rst_n=0): all outputs 0; all channel src/dst/cnt registers 0; FSM in IDLE; round-robin pointer at 0.
- Config: cfg_wr to an idle channel loads src/dst/cnt and sets ch_busy[ch] on the next edge. cfg_wr to a busy channel is ignored (registers unchanged). cfg_cnt=0 sets no busy; ch_done[ch] pulses on the next cycle instead, with no bus activity.
- FSM states: IDLE, ARB, RD, WR, UPD.
- IDLE -> ARB when any ch_busy is set.
- ARB (1 cycle): grant the first busy channel at or after rr_ptr, wrapping modulo NUM_CH. Load burst counter = BURST_LEN. Go to RD.
- RD: bus_rd=1, bus_addr=src[g]. Hold until bus_ready=1. On that edge, capture bus_rdata into the hold register and go to WR.
- WR: bus_wr=1, bus_addr=dst[g], bus_wdata=hold. Hold until bus_ready=1, then go to UPD.
- bus_rd and bus_wr are never high together. Both are low in IDLE, ARB and UPD.
- UPD (1 cycle): src+=1, dst+=1 (wrap modulo 2^ADDR_W); cnt-=1; burst-=1. Then:
  - cnt reaches 0: clear ch_busy[g], pulse ch_done[g], set rr_ptr=g+1, go to ARB if any other channel is busy, else IDLE.
  - burst reaches 0 (cnt>0): set rr_ptr=g+1, go to ARB.
  - otherwise: go to RD.
- Minimum latency per word with bus_ready tied high: RD 1 + WR 1 + UPD 1 = 3 cycles. First access appears 2 cycles after cfg_wr (busy edge, ARB).
- cfg_wr to a different idle channel during a transfer is accepted and does not disturb the active channel.
- rst_n low mid-transfer aborts immediately. Bus strobes drop asynchronously. Partially moved data stays as written.
- NUM_CH=1: arbitration is trivial, and re-grant after a burst still passes through ARB.

Optional Feature:
Macro DMA_MC_IRQ_EN.
- Defined: adds output irq (1 bit), inputs irq_clr (NUM_CH) and irq_mask (NUM_CH), and a sticky per-channel status register.
  - ch_done sets status[ch].
  - irq_clr[ch]=1 clears it on the next edge. If set and clear occur in the same cycle, set wins.
  - irq = OR(status & ~irq_mask), registered.
  - Reset clears status and irq.
- Undefined: no irq ports, no status logic; ch_done pulses are the only completion signal.

Test Plan:
- Single channel, bus_ready=1: cfg ch0 src=64 dst=70 cnt=3, mem[64..66]=4,5,6. Expect mem[70..72]=4,5,6, ch_done[0] pulse 1 cycle after the 3rd write, 9 cycles of RD/WR/UPD activity.
- Round-robin, BURST_LEN=2: ch0 cnt=4 and ch1 cnt=4 programmed in the same window. Expect bus sequence ch0,ch0,ch1,ch1,ch0,ch0,ch1,ch1; ch_done[0] then ch_done[1].
- Wait states: bus_ready low for 3 cycles in each RD and WR. Expect strobes and address held stable, data correct, no extra count decrement.
- Boundaries: cfg_cnt=0 -> ch_done pulse, no bus_rd. Src=2^ADDR_W-1 with cnt=2 -> second read at address 0. cfg_wr to a busy channel -> ignored.
- Reset mid-transfer: assert rst_n low during WR of word 2 of 5. Expect bus_wr=0 immediately, ch_busy=0, and no ch_done after release.
- DMA_MC_IRQ_EN: complete ch2 with mask=0 -> irq=1. irq_clr[2] -> irq=0. Repeat with mask[2]=1 -> irq stays 0 while status[2]=1.
